calc_op_sequencer: RTL and testbench
====================================

CALC_OP_SEQUENCER -- requirements
Module: calc_op_sequencer

Interface
REQ-001 SHALL have port clock, input, 1 bit: single rising-edge clock (display-divided domain).
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port op_req, input, 4 bits: level-held, debounced op buttons; bit0 add, bit1 sub, bit2 mul, bit3 div.
REQ-004 SHALL have ports opa and opb, inputs, 7 bits each: binary operands, 0..99.
REQ-005 SHALL have port alu_op, output, 2 bits: operation to the shared ALU; 0 add, 1 sub, 2 mul, 3 div.
REQ-006 SHALL have ports alu_a and alu_b, outputs, 7 bits each: latched operands driven to the ALU.
REQ-007 SHALL have port alu_start, output, 1 bit: one-cycle start pulse.
REQ-008 SHALL have port alu_done, input, 1 bit: ALU completion strobe.
REQ-009 SHALL have ports alu_result (input, 14 bits, magnitude) and alu_neg (input, 1 bit, sign).
REQ-010 SHALL have port digits, output, 16 bits: four BCD digits; [3:0] ones through [15:12] thousands.
REQ-011 SHALL have ports neg, show_result, busy and err, outputs, 1 bit each: sign, result-valid, op-in-flight and error flags.

Function
REQ-012 SHALL implement states IDLE, ISSUE, WAIT, CONV and HOLD.
REQ-013 IDLE: if op_req has exactly one bit set, SHALL latch op code, opa and opb, and go to ISSUE next cycle; zero or multiple bits set SHALL leave the FSM in IDLE.
REQ-014 ISSUE: SHALL assert alu_start for exactly one cycle with alu_op, alu_a and alu_b valid, then go to WAIT.
REQ-015 WAIT: on alu_done=1, SHALL capture alu_result and alu_neg and go to CONV.
REQ-016 WAIT: a 5-bit timeout counter SHALL increment each cycle; on reaching 31 with no alu_done, SHALL set err=1, set digits to 16'hAAAA and go to HOLD.
REQ-017 CONV: SHALL run shift-add-3 binary-to-BCD conversion, one bit per cycle, exactly 14 cycles, then go to HOLD.
REQ-018 A captured result greater than 9999 SHALL saturate digits to 16'h9999 and set err=1.
REQ-019 HOLD: show_result=1 and digits/neg held stable while op_req is nonzero; op_req==0 SHALL return the FSM to IDLE with show_result=0 on the next edge.
REQ-020 busy SHALL be 1 in ISSUE, WAIT and CONV, and 0 otherwise.
REQ-021 Changes to op_req, opa or opb while busy=1 or in HOLD SHALL be ignored; alu_a, alu_b and alu_op SHALL stay at their latched values.
REQ-022 alu_done while not in WAIT SHALL be ignored.
REQ-023 Latency: op_req valid at edge N gives alu_start at N+1; alu_done at edge M gives show_result=1 at M+15.
REQ-024 err SHALL clear on the IDLE-to-ISSUE transition.

Reset
REQ-025 reset=1 at a clock edge SHALL force IDLE from any state, including mid-CONV or mid-WAIT.
REQ-026 On reset, SHALL clear alu_start, busy, show_result, err, neg, digits, alu_op, alu_a, alu_b and the timeout counter to 0.
REQ-027 reset SHALL take priority over all other inputs on the same edge.

Configuration
REQ-028 With macro CALC_DIVZERO_EN defined, a div op with opb==0 SHALL go IDLE->HOLD directly, with no alu_start, err=1 and digits=16'hAAAA.
REQ-029 Without CALC_DIVZERO_EN defined, a div op with opb==0 SHALL be issued to the ALU like any other op.

Verification
REQ-030 Add: opa=12, opb=34, op_req=0001 -> one alu_start with alu_op=0; ALU returns 46 -> digits=16'h0046, neg=0, show_result at done+15.
REQ-031 Mul with op_req changed mid-WAIT: opa=99, opb=99, mul, then op_req=0010 during WAIT -> alu_op stays 2; result 9801 -> digits=16'h9801.
REQ-032 Simultaneous buttons: op_req=0101 held for 10 cycles -> no alu_start, busy=0; release to 0100 -> mul issued.
REQ-033 Timeout: alu_done never asserted -> err=1, digits=16'hAAAA after 31 WAIT cycles; op_req=0 -> IDLE, show_result=0.
REQ-034 Reset during CONV at cycle 7 -> next edge state IDLE, digits=0, busy=0, no stale result shown.
REQ-035 Divide by zero: opb=0, div -> with CALC_DIVZERO_EN, no alu_start and err=1; without it, alu_start issued once.

Source files
------------

// File: rtl/calc_op_sequencer.sv
// calc_op_sequencer: latches one calculator op, drives the shared ALU, converts the result to BCD.
// Optional CALC_DIVZERO_EN: div by zero is rejected in IDLE without starting the ALU.
module calc_op_sequencer (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic [3:0]  op_req_i,
    input  logic [6:0]  opa_i,
    input  logic [6:0]  opb_i,
    output logic [1:0]  alu_op_o,
    output logic [6:0]  alu_a_o,
    output logic [6:0]  alu_b_o,
    output logic        alu_start_o,
    input  logic        alu_done_i,
    input  logic [13:0] alu_result_i,
    input  logic        alu_neg_i,
    output logic [15:0] digits_o,
    output logic        neg_o,
    output logic        show_result_o,
    output logic        busy_o,
    output logic        err_o
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CONV, HOLD} state_t;
    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [6:0]  a_q, a_d, b_q, b_d;
    logic [4:0]  tmo_q, tmo_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [13:0] bin_q, bin_d;
    logic [15:0] bcd_q, bcd_d, digits_q, digits_d, adj;
    logic        neg_q, neg_d, err_q, err_d, sat_q, sat_d;
    logic        one_hot, div_zero;
    logic [1:0]  req_op;
    assign one_hot = (op_req_i != 4'd0) && ((op_req_i & (op_req_i - 4'd1)) == 4'd0);
    assign req_op  = {op_req_i[3] | op_req_i[2], op_req_i[3] | op_req_i[1]};
`ifdef CALC_DIVZERO_EN
    assign div_zero = op_req_i[3] && (opb_i == 7'd0);
`else
    assign div_zero = 1'b0;
`endif
    // add-3 correction applied to every BCD nibble before each shift
    for (genvar d = 0; d < 4; d++) begin : g_adj
        assign adj[4*d+:4] = (bcd_q[4*d+:4] > 4'd4) ? bcd_q[4*d+:4] + 4'd3 : bcd_q[4*d+:4];
    end
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            op_q     <= 2'd0;
            a_q      <= 7'd0;
            b_q      <= 7'd0;
            tmo_q    <= 5'd0;
            cnt_q    <= 4'd0;
            bin_q    <= 14'd0;
            bcd_q    <= 16'd0;
            digits_q <= 16'd0;
            neg_q    <= 1'b0;
            err_q    <= 1'b0;
            sat_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            tmo_q    <= tmo_d;
            cnt_q    <= cnt_d;
            bin_q    <= bin_d;
            bcd_q    <= bcd_d;
            digits_q <= digits_d;
            neg_q    <= neg_d;
            err_q    <= err_d;
            sat_q    <= sat_d;
        end
    end
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        tmo_d    = tmo_q;
        cnt_d    = cnt_q;
        bin_d    = bin_q;
        bcd_d    = bcd_q;
        digits_d = digits_q;
        neg_d    = neg_q;
        err_d    = err_q;
        sat_d    = sat_q;
        case (state_q)
            IDLE: if (one_hot) begin
                op_d = req_op;
                a_d  = opa_i;
                b_d  = opb_i;
                if (div_zero) begin
                    state_d  = HOLD;
                    err_d    = 1'b1;
                    neg_d    = 1'b0;
                    digits_d = 16'hAAAA;
                end else begin
                    state_d = ISSUE;
                    err_d   = 1'b0;
                    tmo_d   = 5'd0;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: if (alu_done_i) begin
                state_d = CONV;
                bin_d   = alu_result_i;
                neg_d   = alu_neg_i;
                sat_d   = alu_result_i > 14'd9999;
                bcd_d   = 16'd0;
                cnt_d   = 4'd0;
            end else begin
                tmo_d = tmo_q + 5'd1;
                if (tmo_q == 5'd30) begin
                    state_d  = HOLD;
                    err_d    = 1'b1;
                    neg_d    = 1'b0;
                    digits_d = 16'hAAAA;
                end
            end
            CONV: begin
                bcd_d = {adj[14:0], bin_q[13]};
                bin_d = {bin_q[12:0], 1'b0};
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd13) begin
                    state_d  = HOLD;
                    err_d    = sat_q;
                    digits_d = sat_q ? 16'h9999 : {adj[14:0], bin_q[13]};
                end
            end
            HOLD: if (op_req_i == 4'd0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    assign alu_op_o      = op_q;
    assign alu_a_o       = a_q;
    assign alu_b_o       = b_q;
    assign alu_start_o   = state_q == ISSUE;
    assign busy_o        = (state_q == ISSUE) || (state_q == WAIT) || (state_q == CONV);
    assign show_result_o = state_q == HOLD;
    assign digits_o      = digits_q;
    assign neg_o         = neg_q;
    assign err_o         = err_q;
endmodule

// File: tb/tb_calc_op_sequencer.sv
// tb_calc_op_sequencer: directed ops with a scoreboard of expected {digits, neg, err} per shown result.
module tb_calc_op_sequencer;
    logic        clk = 1'b0;
    logic        reset, alu_done, alu_neg, alu_start, neg, show, busy, err;
    logic [3:0]  op_req;
    logic [6:0]  opa, opb, alu_a, alu_b;
    logic [1:0]  alu_op;
    logic [13:0] alu_result;
    logic [15:0] digits;
    int          n_checks = 0, n_fail = 0, cyc = 0, starts = 0, exp_starts = 0;
    logic [17:0] exp_q[$];
    logic        prev_show = 1'b0;

    calc_op_sequencer dut (
        .clock_i(clk), .reset_i(reset), .op_req_i(op_req), .opa_i(opa), .opb_i(opb),
        .alu_op_o(alu_op), .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_start_o(alu_start),
        .alu_done_i(alu_done), .alu_result_i(alu_result), .alu_neg_i(alu_neg),
        .digits_o(digits), .neg_o(neg), .show_result_o(show), .busy_o(busy), .err_o(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge clk) if (alu_start) starts++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every rising show_result consumes one expected response
    initial forever begin
        @(negedge clk);
        if (show && !prev_show) begin
            if (exp_q.size() == 0) check("unexpected_show", 1, 0);
            else begin
                logic [17:0] e;
                e = exp_q.pop_front();
                check("sb_digits", digits, e[17:2]);
                check("sb_neg", neg, e[1]);
                check("sb_err", err, e[0]);
            end
        end
        prev_show = show;
    end

    task automatic wait_start();
        int k = 0;
        while (!alu_start && k < 20) begin @(negedge clk); k++; end
    endtask

    task automatic wait_show();
        int k = 0;
        while (!show && k < 60) begin @(negedge clk); k++; end
    endtask

    task automatic run_op(input logic [3:0] req, input logic [6:0] a, input logic [6:0] b,
                          input logic [1:0] eop, input logic [3:0] mid, input logic [13:0] res,
                          input logic rneg, input logic [15:0] ed, input logic ee);
        int t0;
        @(negedge clk);
        op_req = req; opa = a; opb = b; t0 = cyc;
        wait_start();
        exp_starts++;
        check("start_latency", cyc - t0, 1);
        check("issue_op_a_b", {alu_op, alu_a, alu_b}, {eop, a, b});
        if (mid != 4'd0) begin op_req = mid; opa = 7'd5; opb = 7'd6; end
        repeat (3) @(negedge clk);
        check("wait_busy", busy, 1);
        check("latched_op_a_b", {alu_op, alu_a, alu_b}, {eop, a, b});
        exp_q.push_back({ed, rneg, ee});
        alu_done = 1'b1; alu_result = res; alu_neg = rneg; t0 = cyc;
        @(negedge clk);
        alu_done = 1'b0; alu_result = 14'h3FFF; alu_neg = 1'b0;
        wait_show();
        check("show_latency", cyc - t0, 15);
        op_req = 4'd0;
        repeat (2) @(negedge clk);
        check("release_show", show, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int t0;
        logic bad;
        reset = 1'b1; op_req = 4'd0; opa = 7'd0; opb = 7'd0;
        alu_done = 1'b0; alu_result = 14'd0; alu_neg = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {digits, neg, show, busy, err, alu_start, alu_op, alu_a, alu_b},
              36'd0);
        reset = 1'b0;
        @(negedge clk);
        run_op(4'b0001, 7'd12, 7'd34, 2'd0, 4'd0, 14'd46, 1'b0, 16'h0046, 1'b0);
        run_op(4'b0100, 7'd99, 7'd99, 2'd2, 4'b0010, 14'd9801, 1'b0, 16'h9801, 1'b0);
        run_op(4'b0010, 7'd12, 7'd34, 2'd1, 4'd0, 14'd22, 1'b1, 16'h0022, 1'b0);
        run_op(4'b1000, 7'd99, 7'd1, 2'd3, 4'd0, 14'd9999, 1'b0, 16'h9999, 1'b0);
        run_op(4'b0100, 7'd80, 7'd90, 2'd2, 4'd0, 14'd12345, 1'b0, 16'h9999, 1'b1);
        run_op(4'b0001, 7'd0, 7'd0, 2'd0, 4'd0, 14'd0, 1'b0, 16'h0000, 1'b0);
        // two buttons at once must never issue
        op_req = 4'b0101; opa = 7'd7; opb = 7'd8; bad = 1'b0;
        repeat (10) begin @(negedge clk); bad = bad | busy | alu_start; end
        check("multi_button_idle", bad, 0);
        run_op(4'b0100, 7'd7, 7'd8, 2'd2, 4'd0, 14'd56, 1'b0, 16'h0056, 1'b0);
        // timeout: ALU never answers
        @(negedge clk);
        op_req = 4'b0001; opa = 7'd1; opb = 7'd2;
        wait_start();
        exp_starts++;
        t0 = cyc;
        exp_q.push_back({16'hAAAA, 1'b0, 1'b1});
        wait_show();
        check("timeout_latency", cyc - t0, 32);
        op_req = 4'd0;
        repeat (2) @(negedge clk);
        check("timeout_release", {show, busy}, 0);
        // reset in the middle of CONV
        op_req = 4'b0001; opa = 7'd40; opb = 7'd2;
        wait_start();
        exp_starts++;
        repeat (2) @(negedge clk);
        alu_done = 1'b1; alu_result = 14'd42;
        @(negedge clk);
        alu_done = 1'b0;
        repeat (6) @(negedge clk);
        check("conv_busy", busy, 1);
        reset = 1'b1; op_req = 4'd0;
        @(negedge clk);
        check("reset_mid_conv", {digits, show, busy, err}, 0);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("no_stale_show", show, 0);
        // alu_done outside WAIT is ignored
        alu_done = 1'b1; alu_result = 14'd1234;
        @(negedge clk);
        alu_done = 1'b0;
        repeat (3) @(negedge clk);
        check("stray_done", {show, busy}, 0);
`ifdef CALC_DIVZERO_EN
        t0 = starts;
        exp_q.push_back({16'hAAAA, 1'b0, 1'b1});
        op_req = 4'b1000; opa = 7'd50; opb = 7'd0;
        wait_show();
        check("divzero_no_start", starts - t0, 0);
        op_req = 4'd0;
        repeat (2) @(negedge clk);
`else
        run_op(4'b1000, 7'd50, 7'd0, 2'd3, 4'd0, 14'd0, 1'b0, 16'h0000, 1'b0);
`endif
        repeat (3) @(negedge clk);
        check("start_count", starts, exp_starts);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
